// File: rtl/vtx_trace_capture_pkg.sv
// Shared sizes, FSM encoding and CPR helper for the COP retirement trace capture.
// Pure definitions; no logic, no latency, no backpressure.
// The memory log is fixed at MAX_TXN slots of XLEN-bit words plus a 4-bit byte-enable.
package vtx_trace_capture_pkg;

    localparam int NCPR    = 16;
    localparam int XLEN    = 32;
    localparam int MAX_TXN = 4;
    localparam int CPR_AW  = 4;
    localparam int SLOT_AW = 2;
    localparam int CNT_W   = 3;
    localparam int BEN_W   = 4;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TXN);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } vtx_state_e;

    typedef logic [NCPR-1:0][XLEN-1:0]    cpr_file_t;
    typedef logic [MAX_TXN-1:0][XLEN-1:0] slot_word_t;
    typedef logic [MAX_TXN-1:0][BEN_W-1:0] slot_ben_t;

    // CPR file as it will look after this cycle's write port is applied.
    function automatic cpr_file_t cpr_apply(
        input cpr_file_t         f,
        input logic              wen,
        input logic [CPR_AW-1:0] addr,
        input logic [XLEN-1:0]   data
    );
        cpr_file_t r;
        r = f;
        if (wen) begin
            r[addr] = data;
        end
        return r;
    endfunction

endpackage

// File: rtl/vtx_trace_capture_mem_log.sv
// Per-instruction memory transaction log: MAX_TXN slots, saturating count, overflow flag.
// Request fields land 1 cycle after acceptance; rdata/error 1 cycle later; view_* merges an in-flight response.
// No backpressure: observes the bus only, extra requests set ovf and are dropped.
module vtx_trace_capture_mem_log
    import vtx_trace_capture_pkg::*;
(
    input  logic                       vtx_clk,
    input  logic                       vtx_reset,
    input  logic                       log_en,
    input  logic                       clear,
    input  logic                       mem_cen,
    input  logic                       mem_wen,
    input  logic                       mem_stall,
    input  logic [XLEN-1:0]            mem_addr,
    input  logic [XLEN-1:0]            mem_wdata,
    input  logic [BEN_W-1:0]           mem_ben,
    input  logic [XLEN-1:0]            mem_rdata,
    input  logic                       mem_error,
    output logic [MAX_TXN-1:0]         view_cen,
    output logic [MAX_TXN-1:0]         view_wen,
    output logic [MAX_TXN*XLEN-1:0]    view_addr,
    output logic [MAX_TXN*XLEN-1:0]    view_wdata,
    output logic [MAX_TXN*XLEN-1:0]    view_rdata,
    output logic [MAX_TXN*BEN_W-1:0]   view_ben,
    output logic [MAX_TXN-1:0]         view_error,
    output logic                       view_ovf
);

    logic [MAX_TXN-1:0] s_cen, s_wen, s_error;
    slot_word_t         s_addr, s_wdata, s_rdata;
    slot_ben_t          s_ben;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;
    logic               rsp_pend;
    logic [SLOT_AW-1:0] rsp_slot;

    logic               accept;
    logic [SLOT_AW-1:0] idx;
    slot_word_t         v_rdata;
    logic [MAX_TXN-1:0] v_error;

    assign accept = log_en & mem_cen & ~mem_stall;
    assign idx    = cnt[SLOT_AW-1:0];

    always_ff @(posedge vtx_clk) begin
        if (vtx_reset || clear) begin
            s_cen    <= '0;
            s_wen    <= '0;
            s_error  <= '0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_rdata  <= '0;
            s_ben    <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            rsp_pend <= 1'b0;
            rsp_slot <= '0;
        end else begin
            if (rsp_pend) begin
                s_rdata[rsp_slot] <= mem_rdata;
                s_error[rsp_slot] <= mem_error;
            end
            rsp_pend <= 1'b0;
            if (accept) begin
                if (cnt != CNT_MAX) begin
                    s_cen[idx]   <= 1'b1;
                    s_wen[idx]   <= mem_wen;
                    s_addr[idx]  <= mem_addr;
                    s_wdata[idx] <= mem_wdata;
                    s_ben[idx]   <= mem_ben;
                    cnt          <= cnt + 1'b1;
                    rsp_pend     <= 1'b1;
                    rsp_slot     <= idx;
                end else begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    // A response arriving on the retire cycle must appear in the record.
    always_comb begin
        v_rdata = s_rdata;
        v_error = s_error;
        if (rsp_pend) begin
            v_rdata[rsp_slot] = mem_rdata;
            v_error[rsp_slot] = mem_error;
        end
    end

    assign view_cen   = s_cen;
    assign view_wen   = s_wen;
    assign view_addr  = s_addr;
    assign view_wdata = s_wdata;
    assign view_rdata = v_rdata;
    assign view_ben   = s_ben;
    assign view_error = v_error;
    assign view_ovf   = ovf;

endmodule

// File: rtl/vtx_trace_capture.sv
// Snoops COP issue/retire, CPR writes and the memory bus; emits one trace record per COP instruction.
// Record registered: vtx_valid pulses the cycle after retire, record fields hold until the next pulse.
// No backpressure: pure observer, every input is sampled unconditionally.
module vtx_trace_capture
    import vtx_trace_capture_pkg::*;
(
    input  logic                      vtx_clk,
    input  logic                      vtx_reset,
    input  logic                      cpu_insn_req,
    input  logic                      cop_insn_ack,
    input  logic [31:0]               cpu_insn_enc,
    input  logic [XLEN-1:0]           cpu_rs1,
    input  logic                      cop_rsp_valid,
    input  logic                      cpu_rsp_ack,
    input  logic [2:0]                cop_rsp_result,
    input  logic                      cop_rsp_wen,
    input  logic [4:0]                cop_rsp_waddr,
    input  logic [XLEN-1:0]           cop_rsp_wdata,
    input  logic                      cprs_wen,
    input  logic [CPR_AW-1:0]         cprs_waddr,
    input  logic [XLEN-1:0]           cprs_wdata,
    input  logic                      mem_cen,
    input  logic                      mem_wen,
    input  logic                      mem_stall,
    input  logic [XLEN-1:0]           mem_addr,
    input  logic [XLEN-1:0]           mem_wdata,
    input  logic [BEN_W-1:0]          mem_ben,
    input  logic [XLEN-1:0]           mem_rdata,
    input  logic                      mem_error,
    output logic                      vtx_valid,
    output logic [31:0]               vtx_instr_enc,
    output logic [XLEN-1:0]           vtx_instr_rs1,
    output logic [2:0]                vtx_instr_result,
    output logic                      vtx_instr_wen,
    output logic [4:0]                vtx_instr_waddr,
    output logic [XLEN-1:0]           vtx_instr_wdata,
    output logic [NCPR*XLEN-1:0]      vtx_cprs_pre,
    output logic [NCPR*XLEN-1:0]      vtx_cprs_post,
    output logic [MAX_TXN-1:0]        vtx_mem_cen,
    output logic [MAX_TXN-1:0]        vtx_mem_wen,
    output logic [MAX_TXN*XLEN-1:0]   vtx_mem_addr,
    output logic [MAX_TXN*XLEN-1:0]   vtx_mem_wdata,
    output logic [MAX_TXN*XLEN-1:0]   vtx_mem_rdata,
    output logic [MAX_TXN*BEN_W-1:0]  vtx_mem_ben,
    output logic [MAX_TXN-1:0]        vtx_mem_error,
    output logic                      vtx_mem_ovf
);

    vtx_state_e      state_q, state_d;
    cpr_file_t       shadow_q, shadow_d;
    logic [31:0]     pend_enc;
    logic [XLEN-1:0] pend_rs1;
    cpr_file_t       pend_pre;

    logic issue, retire, start, capture, proto_err;

    logic [MAX_TXN-1:0]       log_cen, log_wen, log_error;
    logic [MAX_TXN*XLEN-1:0]  log_addr, log_wdata, log_rdata;
    logic [MAX_TXN*BEN_W-1:0] log_ben;
    logic                     log_ovf;

    assign issue    = cpu_insn_req & cop_insn_ack;
    assign retire   = cop_rsp_valid & cpu_rsp_ack;
    assign shadow_d = cpr_apply(shadow_q, cprs_wen, cprs_waddr, cprs_wdata);

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        capture   = 1'b0;
        proto_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    start   = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (retire) begin
                    capture = 1'b1;
                    if (issue) begin
                        start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (issue) begin
                    proto_err = 1'b1;
                end
            end
        endcase
    end

    vtx_trace_capture_mem_log u_mem_log (
        .vtx_clk    (vtx_clk),
        .vtx_reset  (vtx_reset),
        .log_en     (state_q == ST_BUSY),
        .clear      (start),
        .mem_cen    (mem_cen),
        .mem_wen    (mem_wen),
        .mem_stall  (mem_stall),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ben    (mem_ben),
        .mem_rdata  (mem_rdata),
        .mem_error  (mem_error),
        .view_cen   (log_cen),
        .view_wen   (log_wen),
        .view_addr  (log_addr),
        .view_wdata (log_wdata),
        .view_rdata (log_rdata),
        .view_ben   (log_ben),
        .view_error (log_error),
        .view_ovf   (log_ovf)
    );

    always_ff @(posedge vtx_clk) begin
        if (vtx_reset) begin
            state_q          <= ST_IDLE;
            shadow_q         <= '0;
            pend_enc         <= '0;
            pend_rs1         <= '0;
            pend_pre         <= '0;
            vtx_valid        <= 1'b0;
            vtx_instr_enc    <= '0;
            vtx_instr_rs1    <= '0;
            vtx_instr_result <= '0;
            vtx_instr_wen    <= 1'b0;
            vtx_instr_waddr  <= '0;
            vtx_instr_wdata  <= '0;
            vtx_cprs_pre     <= '0;
            vtx_cprs_post    <= '0;
            vtx_mem_cen      <= '0;
            vtx_mem_wen      <= '0;
            vtx_mem_addr     <= '0;
            vtx_mem_wdata    <= '0;
            vtx_mem_rdata    <= '0;
            vtx_mem_ben      <= '0;
            vtx_mem_error    <= '0;
            vtx_mem_ovf      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            vtx_valid <= capture;
            // Back-to-back: the new pre snapshot equals the retiring post snapshot.
            if (start) begin
                pend_enc <= cpu_insn_enc;
                pend_rs1 <= cpu_rs1;
                pend_pre <= shadow_d;
            end
            if (capture) begin
                vtx_instr_enc    <= pend_enc;
                vtx_instr_rs1    <= pend_rs1;
                vtx_instr_result <= cop_rsp_result;
                vtx_instr_wen    <= cop_rsp_wen;
                vtx_instr_waddr  <= cop_rsp_waddr;
                vtx_instr_wdata  <= cop_rsp_wdata;
                vtx_cprs_pre     <= pend_pre;
                vtx_cprs_post    <= shadow_d;
                vtx_mem_cen      <= log_cen;
                vtx_mem_wen      <= log_wen;
                vtx_mem_addr     <= log_addr;
                vtx_mem_wdata    <= log_wdata;
                vtx_mem_rdata    <= log_rdata;
                vtx_mem_ben      <= log_ben;
                vtx_mem_error    <= log_error;
                vtx_mem_ovf      <= log_ovf;
            end
        end
    end

    // Issuing while an instruction is outstanding (and not retiring) is ignored by the FSM.
    no_overlapping_issue: assert property (@(posedge vtx_clk) disable iff (vtx_reset) !proto_err);

endmodule

// File: tb/tb_vtx_trace_capture.sv
// Directed bench for vtx_trace_capture: issue/retire timing, CPR snapshots, memory log, reset abort.
module tb_vtx_trace_capture;

    logic         vtx_clk;
    logic         vtx_reset;
    logic         cpu_insn_req, cop_insn_ack;
    logic [31:0]  cpu_insn_enc, cpu_rs1;
    logic         cop_rsp_valid, cpu_rsp_ack;
    logic [2:0]   cop_rsp_result;
    logic         cop_rsp_wen;
    logic [4:0]   cop_rsp_waddr;
    logic [31:0]  cop_rsp_wdata;
    logic         cprs_wen;
    logic [3:0]   cprs_waddr;
    logic [31:0]  cprs_wdata;
    logic         mem_cen, mem_wen, mem_stall;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic [3:0]   mem_ben;
    logic         mem_error;

    logic         vtx_valid;
    logic [31:0]  vtx_instr_enc, vtx_instr_rs1, vtx_instr_wdata;
    logic [2:0]   vtx_instr_result;
    logic         vtx_instr_wen;
    logic [4:0]   vtx_instr_waddr;
    logic [511:0] vtx_cprs_pre, vtx_cprs_post;
    logic [3:0]   vtx_mem_cen, vtx_mem_wen, vtx_mem_error;
    logic [127:0] vtx_mem_addr, vtx_mem_wdata, vtx_mem_rdata;
    logic [15:0]  vtx_mem_ben;
    logic         vtx_mem_ovf;

    int n_cmp;
    int n_fail;
    logic [511:0] exp_c5, exp_c15;

    vtx_trace_capture dut (
        .vtx_clk(vtx_clk), .vtx_reset(vtx_reset),
        .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
        .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
        .cop_rsp_valid(cop_rsp_valid), .cpu_rsp_ack(cpu_rsp_ack),
        .cop_rsp_result(cop_rsp_result), .cop_rsp_wen(cop_rsp_wen),
        .cop_rsp_waddr(cop_rsp_waddr), .cop_rsp_wdata(cop_rsp_wdata),
        .cprs_wen(cprs_wen), .cprs_waddr(cprs_waddr), .cprs_wdata(cprs_wdata),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_stall(mem_stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ben(mem_ben),
        .mem_rdata(mem_rdata), .mem_error(mem_error),
        .vtx_valid(vtx_valid),
        .vtx_instr_enc(vtx_instr_enc), .vtx_instr_rs1(vtx_instr_rs1),
        .vtx_instr_result(vtx_instr_result), .vtx_instr_wen(vtx_instr_wen),
        .vtx_instr_waddr(vtx_instr_waddr), .vtx_instr_wdata(vtx_instr_wdata),
        .vtx_cprs_pre(vtx_cprs_pre), .vtx_cprs_post(vtx_cprs_post),
        .vtx_mem_cen(vtx_mem_cen), .vtx_mem_wen(vtx_mem_wen),
        .vtx_mem_addr(vtx_mem_addr), .vtx_mem_wdata(vtx_mem_wdata),
        .vtx_mem_rdata(vtx_mem_rdata), .vtx_mem_ben(vtx_mem_ben),
        .vtx_mem_error(vtx_mem_error), .vtx_mem_ovf(vtx_mem_ovf)
    );

    initial vtx_clk = 1'b0;
    always #5 vtx_clk = ~vtx_clk;

    task automatic step();
        @(posedge vtx_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] enc, input logic [31:0] rs1);
        cpu_insn_req = 1'b1; cop_insn_ack = 1'b1;
        cpu_insn_enc = enc;  cpu_rs1 = rs1;
        step();
        cpu_insn_req = 1'b0; cop_insn_ack = 1'b0;
    endtask

    task automatic retire();
        cop_rsp_valid = 1'b1; cpu_rsp_ack = 1'b1;
        step();
        cop_rsp_valid = 1'b0; cpu_rsp_ack = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        vtx_reset = 1'b1;
        cpu_insn_req = 0; cop_insn_ack = 0; cpu_insn_enc = 0; cpu_rs1 = 0;
        cop_rsp_valid = 0; cpu_rsp_ack = 0; cop_rsp_result = 0; cop_rsp_wen = 0;
        cop_rsp_waddr = 0; cop_rsp_wdata = 0;
        cprs_wen = 0; cprs_waddr = 0; cprs_wdata = 0;
        mem_cen = 0; mem_wen = 0; mem_stall = 0; mem_addr = 0; mem_wdata = 0;
        mem_rdata = 0; mem_ben = 0; mem_error = 0;
        exp_c5 = '0;  exp_c5[5*32 +: 32] = 32'hDEAD_BEEF;
        exp_c15 = exp_c5; exp_c15[1*32 +: 32] = 32'h0000_0005;

        step(); step();
        chk("rst_valid", 512'(vtx_valid), 512'(0));
        chk("rst_enc",   512'(vtx_instr_enc), 512'(0));
        chk("rst_post",  vtx_cprs_post, '0);
        chk("rst_cen",   512'(vtx_mem_cen), 512'(0));
        vtx_reset = 1'b0;

        // Basic issue, retire three cycles later.
        issue(32'h0000_102B, 32'h0000_1234);
        step(); step();
        cop_rsp_result = 3'd5; cop_rsp_wen = 1'b1; cop_rsp_waddr = 5'd7; cop_rsp_wdata = 32'hCAFE_0001;
        chk("t1_no_valid_early", 512'(vtx_valid), 512'(0));
        retire();
        chk("t1_valid",  512'(vtx_valid), 512'(1));
        chk("t1_enc",    512'(vtx_instr_enc), 512'(32'h0000_102B));
        chk("t1_rs1",    512'(vtx_instr_rs1), 512'(32'h0000_1234));
        chk("t1_result", 512'(vtx_instr_result), 512'(5));
        chk("t1_wen",    512'(vtx_instr_wen), 512'(1));
        chk("t1_waddr",  512'(vtx_instr_waddr), 512'(7));
        chk("t1_wdata",  512'(vtx_instr_wdata), 512'(32'hCAFE_0001));
        chk("t1_pre",    vtx_cprs_pre, '0);
        chk("t1_post",   vtx_cprs_post, '0);
        chk("t1_cen",    512'(vtx_mem_cen), 512'(0));
        step();
        chk("t1_valid_drop", 512'(vtx_valid), 512'(0));
        chk("t1_enc_hold",   512'(vtx_instr_enc), 512'(32'h0000_102B));

        // CPR write while busy.
        cop_rsp_wen = 1'b0; cop_rsp_result = 3'd0;
        issue(32'h0000_2000, 32'h0);
        cprs_wen = 1'b1; cprs_waddr = 4'd5; cprs_wdata = 32'hDEAD_BEEF;
        step();
        cprs_wen = 1'b0;
        retire();
        chk("t2_valid", 512'(vtx_valid), 512'(1));
        chk("t2_pre",   vtx_cprs_pre, '0);
        chk("t2_post",  vtx_cprs_post, exp_c5);

        // Two loads; the second response lands on the retire cycle.
        issue(32'h0000_3000, 32'h0);
        mem_cen = 1'b1; mem_wen = 1'b0; mem_addr = 32'h100; mem_ben = 4'hF;
        step();
        mem_addr = 32'h104; mem_rdata = 32'h11;
        step();
        mem_cen = 1'b0; mem_rdata = 32'h22;
        retire();
        mem_rdata = 32'h0;
        chk("t3_valid", 512'(vtx_valid), 512'(1));
        chk("t3_cen",   512'(vtx_mem_cen), 512'(4'b0011));
        chk("t3_wen",   512'(vtx_mem_wen), 512'(0));
        chk("t3_addr",  512'(vtx_mem_addr), 512'({32'h0, 32'h0, 32'h104, 32'h100}));
        chk("t3_rdata", 512'(vtx_mem_rdata), 512'({32'h0, 32'h0, 32'h22, 32'h11}));
        chk("t3_ben",   512'(vtx_mem_ben), 512'(16'h00FF));
        chk("t3_ovf",   512'(vtx_mem_ovf), 512'(0));
        chk("t3_pre",   vtx_cprs_pre, exp_c5);

        // Five accepted stores (one stalled attempt first): fifth dropped, overflow set.
        issue(32'h0000_4000, 32'h0);
        mem_cen = 1'b1; mem_wen = 1'b1; mem_stall = 1'b1; mem_addr = 32'hBAD; mem_ben = 4'h3;
        step();
        mem_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_addr = 32'h200 + 32'(4 * i);
            mem_wdata = 32'hA0 + 32'(i);
            step();
        end
        mem_cen = 1'b0; mem_wen = 1'b0;
        retire();
        chk("t4_cen",   512'(vtx_mem_cen), 512'(4'hF));
        chk("t4_wen",   512'(vtx_mem_wen), 512'(4'hF));
        chk("t4_addr",  512'(vtx_mem_addr), 512'({32'h20C, 32'h208, 32'h204, 32'h200}));
        chk("t4_wdata", 512'(vtx_mem_wdata), 512'({32'hA3, 32'hA2, 32'hA1, 32'hA0}));
        chk("t4_ben",   512'(vtx_mem_ben), 512'(16'h3333));
        chk("t4_ovf",   512'(vtx_mem_ovf), 512'(1));

        // Retire and issue together with a same-cycle CPR write.
        issue(32'h0000_5000, 32'h0);
        cprs_wen = 1'b1; cprs_waddr = 4'd1; cprs_wdata = 32'h5;
        cop_rsp_valid = 1'b1; cpu_rsp_ack = 1'b1;
        cpu_insn_req = 1'b1; cop_insn_ack = 1'b1; cpu_insn_enc = 32'h0000_5001; cpu_rs1 = 32'h55;
        step();
        cprs_wen = 1'b0; cop_rsp_valid = 1'b0; cpu_rsp_ack = 1'b0;
        cpu_insn_req = 1'b0; cop_insn_ack = 1'b0;
        chk("t5a_valid", 512'(vtx_valid), 512'(1));
        chk("t5a_enc",   512'(vtx_instr_enc), 512'(32'h0000_5000));
        chk("t5a_post",  vtx_cprs_post, exp_c15);
        chk("t5a_ovf",   512'(vtx_mem_ovf), 512'(0));
        step();
        chk("t5_gap",    512'(vtx_valid), 512'(0));
        retire();
        chk("t5b_valid", 512'(vtx_valid), 512'(1));
        chk("t5b_enc",   512'(vtx_instr_enc), 512'(32'h0000_5001));
        chk("t5b_rs1",   512'(vtx_instr_rs1), 512'(32'h55));
        chk("t5b_pre",   vtx_cprs_pre, exp_c15);

        // Reset while busy (with a retire in the reset cycle) discards the record.
        issue(32'h0000_6000, 32'h66);
        mem_cen = 1'b1; mem_addr = 32'h300;
        step();
        mem_cen = 1'b0;
        vtx_reset = 1'b1; cop_rsp_valid = 1'b1; cpu_rsp_ack = 1'b1;
        step();
        vtx_reset = 1'b0;
        chk("t6_valid", 512'(vtx_valid), 512'(0));
        chk("t6_enc",   512'(vtx_instr_enc), 512'(0));
        chk("t6_pre",   vtx_cprs_pre, '0);
        chk("t6_post",  vtx_cprs_post, '0);
        step();
        cop_rsp_valid = 1'b0; cpu_rsp_ack = 1'b0;
        step();
        chk("t6_no_late_valid", 512'(vtx_valid), 512'(0));
        issue(32'h0000_7000, 32'h0);
        retire();
        chk("t6_after_valid", 512'(vtx_valid), 512'(1));
        chk("t6_after_enc",   512'(vtx_instr_enc), 512'(32'h0000_7000));
        chk("t6_shadow_clr",  vtx_cprs_post, '0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
